branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/lc3b_types.sv | 21 ++
 rtl/sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 106 ++++++++++
 tb/tb_branch_predictor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types: BTB entry and 2-bit counter states
package lc3b_types;

    // Widest tag ever needed (ENTRIES=4 leaves pc[15:3]); narrower tags are zero-extended.
    localparam int BTB_TAG_W = 13;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef logic [BTB_TAG_W-1:0] btb_tag_t;

    typedef struct packed {
        logic        valid;
        btb_tag_t    tag;
        logic [15:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - next state of a 2-bit saturating taken/not-taken counter
module sat_counter2
    import lc3b_types::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step toward STRONG_T on taken, toward STRONG_NT otherwise, holding at the ends.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != STRONG_T) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != STRONG_NT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and mispredict redirect
module branch_predictor
    import lc3b_types::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] fetch_pc,
    output logic [15:0] pc_predict,
    output logic        prediction_taken,
    input  logic        resolve_valid,
    input  logic [15:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [15:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [15:0] resolve_pred_target,
    output logic        flush,
    output logic        br_sig,
    output logic [15:0] flush_pc,
    output logic [15:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t table_q [ENTRIES];
    logic [15:0] mispredict_count_q;
    logic [15:0] mispredict_count_d;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] r_idx;
    btb_tag_t         f_tag;
    btb_tag_t         r_tag;
    btb_entry_t       f_entry;
    btb_entry_t       r_entry;
    btb_entry_t       entry_d;
    logic             f_hit;
    logic             r_hit;
    logic             upd_en;
    logic [1:0]       ctr_next;

    // Instruction addresses are halfword aligned, so bit 0 carries no information.
    logic unused_pc_bits;
    assign unused_pc_bits = fetch_pc[0] ^ resolve_pc[0];

    assign f_idx   = fetch_pc[IDX_W:1];
    assign r_idx   = resolve_pc[IDX_W:1];
    assign f_tag   = btb_tag_t'(fetch_pc[15:IDX_W+1]);
    assign r_tag   = btb_tag_t'(resolve_pc[15:IDX_W+1]);
    assign f_entry = table_q[f_idx];
    assign r_entry = table_q[r_idx];
    assign f_hit   = f_entry.valid && (f_entry.tag == f_tag);
    assign r_hit   = r_entry.valid && (r_entry.tag == r_tag);

    // Lookup reads the registered table, so a same-cycle update shows up one cycle later.
    assign prediction_taken = reset_n && f_hit && f_entry.ctr[1];
    assign pc_predict       = prediction_taken ? f_entry.target : 16'h0000;

    assign flush = reset_n && resolve_valid &&
                   ((resolve_pred_taken != resolve_taken) ||
                    (resolve_taken && (resolve_pred_target != resolve_target)));
    assign br_sig           = resolve_taken;
    assign flush_pc         = resolve_pc + 16'd2;
    assign mispredict_count = mispredict_count_q;

    sat_counter2 u_ctr (
        .ctr_i   (r_entry.ctr),
        .taken_i (resolve_taken),
        .ctr_o   (ctr_next)
    );

    // Build the replacement entry for the resolving index: train on hit, allocate on taken miss.
    always_comb begin
        entry_d = r_entry;
        upd_en  = 1'b0;
        if (resolve_valid) begin
            if (r_hit) begin
                upd_en      = 1'b1;
                entry_d.ctr = ctr_next;
                if (resolve_taken) entry_d.target = resolve_target;
            end else if (resolve_taken) begin
                upd_en         = 1'b1;
                entry_d.valid  = 1'b1;
                entry_d.tag    = r_tag;
                entry_d.target = resolve_target;
                entry_d.ctr    = WEAK_T;
            end
        end
    end

    assign mispredict_count_d = flush ? mispredict_count_q + 16'd1 : mispredict_count_q;

    // Table and mispredict counter registers; reset empties the table and weakly biases not-taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: 16'h0000, ctr: WEAK_NT};
            end
            mispredict_count_q <= 16'h0000;
        end else begin
            if (upd_en) table_q[r_idx] <= entry_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks of branch_predictor against a table model
module tb_branch_predictor;

    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] fetch_pc;
    logic [15:0] pc_predict;
    logic        prediction_taken;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        resolve_pred_taken;
    logic [15:0] resolve_pred_target;
    logic        flush;
    logic        br_sig;
    logic [15:0] flush_pc;
    logic [15:0] mispredict_count;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .fetch_pc            (fetch_pc),
        .pc_predict          (pc_predict),
        .prediction_taken    (prediction_taken),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .flush               (flush),
        .br_sig              (br_sig),
        .flush_pc            (flush_pc),
        .mispredict_count    (mispredict_count)
    );

    // Reference model: plain integer arrays indexed by (pc/2) mod ENTRIES.
    bit m_valid  [ENTRIES];
    int m_tag    [ENTRIES];
    int m_target [ENTRIES];
    int m_ctr    [ENTRIES];
    int m_count;
    bit exp_flush;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int idx_of(input int pc);
        return (pc / 2) % ENTRIES;
    endfunction

    function automatic int tag_of(input int pc);
        return pc / (2 * ENTRIES);
    endfunction

    function bit m_hit(input int pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function bit m_pred(input int pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 1;
        end
        m_count = 0;
    endtask

    task automatic check(input string name, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Compare every output against the model for the inputs currently driven.
    task automatic check_all();
        int  fp;
        bit  pt;
        int  pcp;
        fp  = int'(fetch_pc);
        pt  = reset_n && m_pred(fp);
        pcp = pt ? m_target[idx_of(fp)] : 0;
        exp_flush = reset_n && resolve_valid &&
                    ((resolve_pred_taken != resolve_taken) ||
                     (resolve_taken && (resolve_pred_target != resolve_target)));
        check("prediction_taken", {15'd0, prediction_taken}, {15'd0, pt});
        check("pc_predict", pc_predict, 16'(pcp));
        check("flush", {15'd0, flush}, {15'd0, exp_flush});
        check("br_sig", {15'd0, br_sig}, {15'd0, resolve_taken});
        check("flush_pc", flush_pc, 16'((int'(resolve_pc) + 2) % 65536));
        check("mispredict_count", mispredict_count, 16'(m_count));
    endtask

    task automatic drive(input logic [15:0] fpc, input logic rv, input logic [15:0] rpc,
                         input logic rt, input logic [15:0] rtg, input logic rpt,
                         input logic [15:0] rptg);
        @(negedge clk);
        fetch_pc            = fpc;
        resolve_valid       = rv;
        resolve_pc          = rpc;
        resolve_taken       = rt;
        resolve_target      = rtg;
        resolve_pred_taken  = rpt;
        resolve_pred_target = rptg;
        #1;
        check_all();
    endtask

    // Apply the rising edge to the model using the inputs held across it.
    task automatic commit();
        int ri;
        int rp;
        @(posedge clk);
        if (reset_n) begin
            rp = int'(resolve_pc);
            ri = idx_of(rp);
            if (exp_flush) m_count = (m_count + 1) % 65536;
            if (resolve_valid) begin
                if (m_hit(rp)) begin
                    if (resolve_taken) begin
                        m_ctr[ri]    = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
                        m_target[ri] = int'(resolve_target);
                    end else begin
                        m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
                    end
                end else if (resolve_taken) begin
                    m_valid[ri]  = 1'b1;
                    m_tag[ri]    = tag_of(rp);
                    m_target[ri] = int'(resolve_target);
                    m_ctr[ri]    = 2;
                end
            end
        end
    endtask

    task automatic step(input logic [15:0] fpc, input logic rv, input logic [15:0] rpc,
                        input logic rt, input logic [15:0] rtg, input logic rpt,
                        input logic [15:0] rptg);
        drive(fpc, rv, rpc, rt, rtg, rpt, rptg);
        commit();
    endtask

    // Assert reset between edges with a mispredicting resolve on the inputs.
    task automatic reset_pulse(input logic [15:0] fpc);
        @(negedge clk);
        fetch_pc            = fpc;
        resolve_valid       = 1'b1;
        resolve_pc          = fpc;
        resolve_taken       = 1'b1;
        resolve_target      = 16'h0abc;
        resolve_pred_taken  = 1'b0;
        resolve_pred_target = 16'h0000;
        reset_n             = 1'b0;
        model_clear();
        #1;
        check_all();
        check("reset_flush", {15'd0, flush}, 16'd0);
        check("reset_count", mispredict_count, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        resolve_valid = 1'b0;
        reset_n       = 1'b1;
    endtask

    initial begin
        logic [15:0] fpc;
        logic [15:0] rpc;
        logic [15:0] rtg;
        logic        rt;
        logic        rpt;
        logic [15:0] rptg;

        reset_n = 1'b0;
        fetch_pc = 16'h0040;
        resolve_valid = 1'b0;
        resolve_pc = 16'h0000;
        resolve_taken = 1'b0;
        resolve_target = 16'h0000;
        resolve_pred_taken = 1'b0;
        resolve_pred_target = 16'h0000;
        model_clear();
        reset_pulse(16'h0040);

        // Cold lookup after reset.
        drive(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("cold_pred", {15'd0, prediction_taken}, 16'd0);
        commit();

        // First taken resolve allocates and mispredicts.
        drive(16'h0000, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000);
        check("alloc_flush", {15'd0, flush}, 16'd1);
        check("alloc_flush_pc", flush_pc, 16'h0042);
        commit();
        drive(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("alloc_target", pc_predict, 16'h0100);
        check("alloc_count", mispredict_count, 16'h0001);
        commit();

        // Train down to strongly not-taken, then saturate up.
        step(16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0100);
        step(16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000);
        drive(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("trained_nt", {15'd0, prediction_taken}, 16'd0);
        commit();
        for (int i = 0; i < 3; i++) step(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000);
        step(16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0100);
        drive(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("saturated_still_taken", {15'd0, prediction_taken}, 16'd1);
        commit();

        // Aliasing tag replaces the entry.
        step(16'h0000, 1'b1, 16'h0060, 1'b1, 16'h0300, 1'b0, 16'h0000);
        drive(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("alias_miss", {15'd0, prediction_taken}, 16'd0);
        commit();
        step(16'h0060, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Same-cycle fetch and resolve on one index sees old contents.
        drive(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0200, 1'b0, 16'h0000);
        check("same_cycle_old", {15'd0, prediction_taken}, 16'd0);
        commit();
        drive(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("same_cycle_new", pc_predict, 16'h0200);
        commit();

        // Flush address wrap and idle resolve with garbage.
        drive(16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 16'h1234);
        check("wrap_flush_pc", flush_pc, 16'h0000);
        commit();
        step(16'h0040, 1'b0, 16'h0040, 1'b1, 16'h0999, 1'b0, 16'h0000);

        // Random traffic over a small PC range to get hits, aliasing and collisions.
        for (int n = 0; n < 400; n++) begin
            fpc = 16'($urandom_range(0, 255));
            rpc = ($urandom_range(0, 7) == 0) ? fpc : 16'($urandom_range(0, 255));
            rt  = 1'($urandom_range(0, 1));
            rtg = 16'($urandom_range(1, 3) * 256);
            if ($urandom_range(0, 2) != 0) begin
                rpt  = m_pred(int'(rpc));
                rptg = rpt ? 16'(m_target[idx_of(int'(rpc))]) : 16'h0000;
            end else begin
                rpt  = 1'($urandom_range(0, 1));
                rptg = 16'($urandom_range(1, 3) * 256);
            end
            step(fpc, ($urandom_range(0, 3) != 0), rpc, rt, rtg, rpt, rptg);
        end

        // Populate known entries, then reset mid-stream.
        step(16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0500, 1'b0, 16'h0000);
        drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("pre_reset_hit", {15'd0, prediction_taken}, 16'd1);
        commit();
        reset_pulse(16'h0010);
        for (int i = 0; i < ENTRIES; i++) begin
            step(16'(i * 2 + 16'h0010), 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        end
        for (int n = 0; n < 50; n++) begin
            fpc = 16'($urandom_range(0, 255));
            rpc = 16'($urandom_range(0, 255));
            step(fpc, 1'b1, rpc, 1'($urandom_range(0, 1)), 16'h0700, 1'($urandom_range(0, 1)), 16'h0700);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
